icache_bank_arbiter_ic: RTL and testbench
=========================================

Name: icache_bank_arbiter_ic

Overview:
- Per-bank request-side controller of the icache interconnect.
- Shares one icache SCM bank between N_MASTER fetch ports using round-robin arbitration.
- Records which master was granted and replays that as a one-hot response ID, aligned with the bank's fixed-latency read data.
- Its valid/ID outputs feed the response fan-in tree that routes rdata back to masters.

Parameters:
- N_MASTER, 8, number of requesting fetch ports; legal range 2..32.
- ADDR_WIDTH, 32, request address width.
- ID_WIDTH, N_MASTER, response ID width. Must equal N_MASTER because the ID is one-hot.
- RESP_LATENCY, 1, cycles from accepted bank request to bank rdata valid; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_req_i  input  N_MASTER  per-master request.
- data_add_i  input  N_MASTER x ADDR_WIDTH  per-master address.
- data_gnt_o  output  N_MASTER  per-master grant, combinational, at most one bit high.
- bank_req_o  output  1  request to bank.
- bank_add_o  output  ADDR_WIDTH  address of the winning master.
- bank_gnt_i  input  1  bank accepts the request this cycle.
- data_r_valid_o  output  1  response valid, aligned with the bank's rdata.
- data_r_ID_o  output  ID_WIDTH  one-hot ID of the master owning the response.
- req_lock_i  input  N_MASTER  per-master lock request; present only with ICACHE_BANK_ARB_LOCK_EN.

Behaviour:
- Reset:
  - Priority pointer = 0.
  - Response pipeline cleared.
  - data_r_valid_o = 0, data_r_ID_o = 0.
  - bank_req_o = 0 and data_gnt_o = 0 while rst is high.
- Arbitration is combinational:
  - Winner = first requesting master at or after the pointer, scanning upward and wrapping from N_MASTER-1 to 0.
  - bank_req_o = |data_req_i.
  - bank_add_o = data_add_i[winner]; it is 0 when there are no requests.
  - data_gnt_o[winner] = bank_gnt_i; all other grant bits are 0.
- Pointer update, on an accepted request only (bank_req_o & bank_gnt_i):
  - Pointer <= winner+1, wrapping N_MASTER-1 -> 0.
  - No requests, or bank_gnt_i = 0: pointer holds. A stalled winner keeps the grant opportunity.
- Response pipeline:
  - Shift register of RESP_LATENCY stages, each holding {valid, one-hot ID}.
  - Stage 0 loads {1, onehot(winner)} on an accepted request, otherwise {0, 0}.
  - Outputs come from the last stage, so an accept in cycle t gives data_r_valid_o = 1 at cycle t+RESP_LATENCY.
  - When valid = 0 the ID output is forced to 0.
- Back-to-back accepts produce back-to-back responses. The pipeline never stalls; the bank response is not backpressured.
- Single requester: granted every cycle bank_gnt_i = 1, and the pointer keeps moving past it.
- All masters requesting continuously: order 0,1,..,N_MASTER-1,0,...
- Reset mid-operation: in-flight responses are dropped (valid = 0 on the cycle after rst). The bank-side data for those requests is ignored by design.
- No FSM beyond pointer + pipeline. The "locked" state exists only with the optional feature.

Optional Feature:
- Macro: ICACHE_BANK_ARB_LOCK_EN.
- When defined:
  - Port req_lock_i exists.
  - Add lock_valid and lock_owner registers, cleared by reset.
  - An accepted request from master m with req_lock_i[m] = 1 sets lock_valid and lock_owner = m.
  - While locked, only lock_owner can win; other requests are masked, and the pointer does not advance.
  - Lock clears on the first cycle lock_owner has req_lock_i = 0 or data_req_i = 0. That cycle arbitrates normally from pointer = lock_owner+1.
- When undefined: port absent, pure round-robin, no lock registers.

Test Plan (N_MASTER=4, RESP_LATENCY=2 unless noted):
- Reset, then data_req_i = 4'b1111 with bank_gnt_i = 1 for 8 cycles -> data_gnt_o sequence 0001,0010,0100,1000,0001,..; data_r_ID_o shows the same sequence delayed 2 cycles with data_r_valid_o = 1.
- data_req_i = 4'b1010, bank_gnt_i = 0 for 3 cycles, then 1 -> bank_add_o = data_add_i[1] throughout, pointer held, grant 0010 on the accept cycle; next accept grants 1000.
- Only master 2 requests for 5 cycles with bank_gnt_i = 1 -> 5 consecutive grants 0100 and 5 responses with ID 0100 from cycle 2.
- Accept at cycles 0 and 1, rst = 1 at cycle 1 -> data_r_valid_o = 0 at cycles 2 and 3, and pointer = 0 after reset.
- RESP_LATENCY=1, idle then a single accept of master 3 -> data_r_valid_o = 1 exactly 1 cycle later with ID 1000, then 0.
- With ICACHE_BANK_ARB_LOCK_EN: master 1 requests with lock for 4 cycles while 0,2,3 also request -> 4 grants to master 1; on lock drop, the next grant goes to master 2.

Source files
------------

// File: rtl/icache_bank_arbiter_ic_if.sv
// Bus bundle between the fetch ports / SCM bank and one icache bank arbiter.
// The "slave" modport is the arbiter's view; "master" is the environment's view.
// Optional lock lines exist only when ICACHE_BANK_ARB_LOCK_EN is defined.
interface icache_bank_arbiter_ic_if #(
   parameter int N_MASTER   = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = N_MASTER
);
   logic [N_MASTER-1:0]                 data_req_i;
   logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
   logic [N_MASTER-1:0]                 data_gnt_o;
   logic                                bank_req_o;
   logic [ADDR_WIDTH-1:0]               bank_add_o;
   logic                                bank_gnt_i;
   logic                                data_r_valid_o;
   logic [ID_WIDTH-1:0]                 data_r_ID_o;
`ifdef ICACHE_BANK_ARB_LOCK_EN
   logic [N_MASTER-1:0]                 req_lock_i;

   modport slave (
      input  data_req_i, data_add_i, bank_gnt_i, req_lock_i,
      output data_gnt_o, bank_req_o, bank_add_o, data_r_valid_o, data_r_ID_o
   );
   modport master (
      output data_req_i, data_add_i, bank_gnt_i, req_lock_i,
      input  data_gnt_o, bank_req_o, bank_add_o, data_r_valid_o, data_r_ID_o
   );
`else
   modport slave (
      input  data_req_i, data_add_i, bank_gnt_i,
      output data_gnt_o, bank_req_o, bank_add_o, data_r_valid_o, data_r_ID_o
   );
   modport master (
      output data_req_i, data_add_i, bank_gnt_i,
      input  data_gnt_o, bank_req_o, bank_add_o, data_r_valid_o, data_r_ID_o
   );
`endif
endinterface

// File: rtl/icache_bank_arbiter_ic.sv
// Per-bank request-side controller of the icache interconnect.
// Round-robin arbitration of N_MASTER fetch ports onto one SCM bank, plus a
// fixed-latency pipeline that replays the granted master as a one-hot
// response ID aligned with the bank's read data.
// Optional feature macro: ICACHE_BANK_ARB_LOCK_EN (per-master bank lock).
module icache_bank_arbiter_ic #(
   parameter int N_MASTER     = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int ID_WIDTH     = N_MASTER,
   parameter int RESP_LATENCY = 1
) (
   input logic                     clk,
   input logic                     rst,
   icache_bank_arbiter_ic_if.slave bus
);

   localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_MASTER - 1);

   logic [PTR_W-1:0]                       r_ptr;
   logic [RESP_LATENCY-1:0]                r_vld;
   logic [RESP_LATENCY-1:0][ID_WIDTH-1:0]  r_id;

   logic [N_MASTER-1:0] w_req_eff;
   logic                w_lock_hold;
   logic                w_found;
   logic [PTR_W-1:0]    w_winner;
   logic                w_bank_req;
   logic                w_accept;
   logic [ID_WIDTH-1:0] w_onehot;

`ifdef ICACHE_BANK_ARB_LOCK_EN
   logic             r_lock_valid;
   logic [PTR_W-1:0] r_lock_owner;

   // Lock persists only while the owner keeps both request and lock asserted.
   assign w_lock_hold = r_lock_valid & bus.req_lock_i[r_lock_owner] & bus.data_req_i[r_lock_owner];
   assign w_req_eff   = w_lock_hold ? (N_MASTER'(1) << r_lock_owner) : bus.data_req_i;

   // Lock owner tracking: set by a locked accept, dropped when the owner releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock_valid <= 1'b0;
         r_lock_owner <= {PTR_W{1'b0}};
      end else if (w_lock_hold) begin
         r_lock_valid <= 1'b1;
         r_lock_owner <= r_lock_owner;
      end else if (w_accept && bus.req_lock_i[w_winner]) begin
         r_lock_valid <= 1'b1;
         r_lock_owner <= w_winner;
      end else begin
         r_lock_valid <= 1'b0;
         r_lock_owner <= r_lock_owner;
      end
   end
`else
   assign w_lock_hold = 1'b0;
   assign w_req_eff   = bus.data_req_i;
`endif

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      logic [PTR_W:0] v_idx;
      w_found  = 1'b0;
      w_winner = {PTR_W{1'b0}};
      v_idx    = {(PTR_W+1){1'b0}};
      for (int i = 0; i < N_MASTER; i++) begin
         v_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (v_idx >= (PTR_W+1)'(N_MASTER)) begin
            v_idx = v_idx - (PTR_W+1)'(N_MASTER);
         end else begin
            v_idx = v_idx;
         end
         if (!w_found && w_req_eff[v_idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = v_idx[PTR_W-1:0];
         end else begin
            w_found  = w_found;
            w_winner = w_winner;
         end
      end
   end

   assign w_bank_req = ~rst & (|bus.data_req_i);
   assign w_accept   = w_bank_req & bus.bank_gnt_i;
   assign w_onehot   = w_found ? (ID_WIDTH'(1) << w_winner) : {ID_WIDTH{1'b0}};

   assign bus.bank_req_o = w_bank_req;
   assign bus.bank_add_o = w_found ? bus.data_add_i[w_winner] : {ADDR_WIDTH{1'b0}};
   assign bus.data_gnt_o = (w_found && w_accept) ? (N_MASTER'(1) << w_winner) : {N_MASTER{1'b0}};

   // Priority pointer: moves past the winner on every accepted, unlocked request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= {PTR_W{1'b0}};
      end else if (w_accept && !w_lock_hold) begin
         r_ptr <= (w_winner == LAST_IDX) ? {PTR_W{1'b0}} : (w_winner + PTR_W'(1));
      end else begin
         r_ptr <= r_ptr;
      end
   end

   // Response pipeline: {valid, one-hot ID} shifted once per cycle, never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= {RESP_LATENCY{1'b0}};
         r_id  <= {(RESP_LATENCY*ID_WIDTH){1'b0}};
      end else begin
         r_vld[0] <= w_accept;
         r_id[0]  <= w_accept ? w_onehot : {ID_WIDTH{1'b0}};
         for (int s = 1; s < RESP_LATENCY; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_id[s]  <= r_id[s-1];
         end
      end
   end

   assign bus.data_r_valid_o = r_vld[RESP_LATENCY-1];
   assign bus.data_r_ID_o    = r_vld[RESP_LATENCY-1] ? r_id[RESP_LATENCY-1] : {ID_WIDTH{1'b0}};

endmodule

// File: tb/tb_icache_bank_arbiter_ic.sv
// Scoreboard bench for icache_bank_arbiter_ic (N_MASTER=4, RESP_LATENCY=2).
// A driver applies directed and random stimulus at the falling edge, checks
// the combinational arbitration outputs against a round-robin reference
// model, and queues expected responses; a monitor pops and checks them.
module tb_icache_bank_arbiter_ic;

   localparam int NM  = 4;
   localparam int AW  = 32;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   icache_bank_arbiter_ic_if #(.N_MASTER(NM), .ADDR_WIDTH(AW), .ID_WIDTH(NM)) bus ();

   icache_bank_arbiter_ic #(
      .N_MASTER(NM), .ADDR_WIDTH(AW), .ID_WIDTH(NM), .RESP_LATENCY(LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [3:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ref_ptr  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
   endtask

   // One bench cycle: drive inputs, compare arbitration against the model.
   task automatic step(input logic [3:0] req, input logic gnt, input logic r);
      logic [AW-1:0] addr [NM];
      logic          found;
      int            win;
      @(negedge clk);
      rst            = r;
      bus.data_req_i = req;
      bus.bank_gnt_i = gnt;
      for (int m = 0; m < NM; m++) begin
         addr[m]           = $urandom;
         bus.data_add_i[m] = addr[m];
      end
      #1;
      found = 1'b0;
      win   = 0;
      if (!r) begin
         for (int k = 0; k < NM; k++) begin
            int m;
            m = (ref_ptr + k) % NM;
            if (!found && req[m]) begin
               found = 1'b1;
               win   = m;
            end
         end
      end
      chk("bank_req", {31'd0, bus.bank_req_o}, {31'd0, found});
      chk("data_gnt", {28'd0, bus.data_gnt_o}, (found && gnt) ? (32'd1 << win) : 32'd0);
      if (!r) chk("bank_add", bus.bank_add_o, found ? addr[win] : 32'd0);
      if (r) begin
         ref_ptr = 0;
         exp_q.delete();
      end else if (found && gnt) begin
         exp_t e;
         e.due = cyc + LAT;
         e.id  = 4'(1 << win);
         exp_q.push_back(e);
         ref_ptr = (win + 1) % NM;
      end
   endtask

   // Monitor: after every rising edge compare response outputs with the queue head.
   always @(posedge clk) begin
      logic exp_v;
      exp_t e;
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("resp_valid", {31'd0, bus.data_r_valid_o}, {31'd0, exp_v});
      if (exp_v) begin
         e = exp_q.pop_front();
         chk("resp_id", {28'd0, bus.data_r_ID_o}, {28'd0, e.id});
      end else begin
         chk("resp_id_idle", {28'd0, bus.data_r_ID_o}, 32'd0);
      end
   end

`ifdef ICACHE_BANK_ARB_LOCK_EN
   initial bus.req_lock_i = 4'b0000;
`endif

   initial begin
      logic [3:0] eg;
      bus.data_req_i = 4'b0000;
      bus.bank_gnt_i = 1'b0;
      bus.data_add_i = '0;

      // Reset
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b1);

      // All masters requesting: strict 0,1,2,3,0,... order
      for (int k = 0; k < 8; k++) begin
         step(4'b1111, 1'b1, 1'b0);
         eg = 4'b0001 << (k % 4);
         chk("rr_order", {28'd0, bus.data_gnt_o}, {28'd0, eg});
      end

      // Stalled winner keeps the opportunity, then 1 then 3
      for (int k = 0; k < 3; k++) step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b1, 1'b0);
      step(4'b1010, 1'b1, 1'b0);

      // Single requester granted back to back
      for (int k = 0; k < 5; k++) step(4'b0100, 1'b1, 1'b0);

      // Reset while responses are in flight
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111, 1'b1, 1'b1);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);

      // Random traffic with occasional resets
      for (int k = 0; k < 400; k++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 59) == 0));
      end

      // Drain
      for (int k = 0; k < LAT + 2; k++) step(4'b0000, 1'b0, 1'b0);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
